// File: rtl/pbdebounce_rpt.sv
// pbdebounce_rpt: multi-channel push-button debouncer with press/release
// strobes, a shared sample-tick prescaler and per-channel auto-repeat.
//
// Ports:
//   clk          system clock, single domain
//   rst_n        synchronous active-low reset
//   btn_in[N]    raw asynchronous button pins
//   rep_en[N]    per-channel auto-repeat enable
//   btn_level[N] debounced state, 1 = pressed
//   btn_press[N] one-clk strobe when btn_level rises
//   btn_release  one-clk strobe when btn_level falls
//   btn_repeat   one-clk auto-repeat strobe while held

module pbdebounce_rpt #(
    parameter int N          = 5,
    parameter int CLK_DIV    = 100000,
    parameter int STABLE     = 8,
    parameter int ACTIVE_LOW = 1,
    parameter int REP_DELAY  = 500,
    parameter int REP_RATE   = 100
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] btn_in,
    input  logic [N-1:0] rep_en,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] btn_repeat
);

    localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW   = $clog2(STABLE);
    localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE - 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REP_RATE - 1);

    // Raw pin value that means "released" for the chosen polarity.
    localparam logic [N-1:0] REL_RAW = {N{ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RPT
    } rpt_state_t;

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic [N-1:0]  sample;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= REL_RAW;
            sync2 <= REL_RAW;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    assign sample = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic [RW-1:0] rcnt;
        rpt_state_t    st;
        logic          lvl;
        logic          prs;
        logic          rel;
        logic          rpt;
        logic          flip;

        // The STABLE-th consecutive disagreeing sample flips the level.
        assign flip = tick && (sample[i] != lvl) && (cnt == CNT_LAST);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt  <= '0;
                rcnt <= '0;
                st   <= IDLE;
                lvl  <= 1'b0;
                prs  <= 1'b0;
                rel  <= 1'b0;
                rpt  <= 1'b0;
            end else begin
                prs <= flip && !lvl;
                rel <= flip && lvl;
                rpt <= 1'b0;

                if (tick) begin
                    if (sample[i] == lvl) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        lvl <= ~lvl;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Level edges take priority: the press edge arms the
                // delay, the release edge silences the channel at once.
                if (flip) begin
                    st   <= lvl ? IDLE : HOLD;
                    rcnt <= '0;
                end else if (tick && st != IDLE) begin
                    if (!rep_en[i]) begin
                        st   <= HOLD;
                        rcnt <= '0;
                    end else begin
                        unique case (st)
                            HOLD: begin
                                if (rcnt == DLY_LAST) begin
                                    rpt  <= 1'b1;
                                    st   <= RPT;
                                    rcnt <= '0;
                                end else begin
                                    rcnt <= rcnt + 1'b1;
                                end
                            end
                            RPT: begin
                                if (rcnt == RATE_LAST) begin
                                    rpt  <= 1'b1;
                                    rcnt <= '0;
                                end else begin
                                    rcnt <= rcnt + 1'b1;
                                end
                            end
                            default: begin
                                st   <= IDLE;
                                rcnt <= '0;
                            end
                        endcase
                    end
                end
            end
        end

        assign btn_level[i]   = lvl;
        assign btn_press[i]   = prs;
        assign btn_release[i] = rel;
        assign btn_repeat[i]  = rpt;
    end

endmodule

// File: tb/tb_pbdebounce_rpt.sv
// tb_pbdebounce_rpt: random button traffic on two instances (CLK_DIV 1 and 4)
// checked every cycle against a tick/run-length/held-time reference model.

module tb_pbdebounce_rpt;

    localparam int N  = 5;
    localparam int ST = 4;
    localparam int RD = 6;
    localparam int RR = 3;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] btn_in;
    logic [N-1:0] rep_en;

    logic [N-1:0] lvl1, prs1, rel1, rpt1;
    logic [N-1:0] lvl4, prs4, rel4, rpt4;

    int checks;
    int failures;

    // Reference model state, index 0 = CLK_DIV 1, index 1 = CLK_DIV 4.
    logic [N-1:0] m_p1  [2];
    logic [N-1:0] m_p2  [2];
    int           m_k   [2];
    int           m_run [2][N];
    bit           m_act [2][N];
    int           m_held[2][N];
    logic [N-1:0] e_lvl [2];
    logic [N-1:0] e_prs [2];
    logic [N-1:0] e_rel [2];
    logic [N-1:0] e_rpt [2];

    pbdebounce_rpt #(
        .N(N), .CLK_DIV(1), .STABLE(ST), .ACTIVE_LOW(1),
        .REP_DELAY(RD), .REP_RATE(RR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .rep_en(rep_en),
        .btn_level(lvl1), .btn_press(prs1),
        .btn_release(rel1), .btn_repeat(rpt1)
    );

    pbdebounce_rpt #(
        .N(N), .CLK_DIV(4), .STABLE(ST), .ACTIVE_LOW(1),
        .REP_DELAY(RD), .REP_RATE(RR)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .rep_en(rep_en),
        .btn_level(lvl4), .btn_press(prs4),
        .btn_release(rel4), .btn_repeat(rpt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference: a pin is seen by the qualifier two
    // edges after it is captured; ticks fall every d-th edge after reset.
    task automatic model_step(input int u, input int d, input logic rst,
                              input logic [N-1:0] pin,
                              input logic [N-1:0] en);
        logic [N-1:0] smp;
        bit           tk;
        e_prs[u] = '0;
        e_rel[u] = '0;
        e_rpt[u] = '0;
        if (!rst) begin
            m_p1[u]  = '1;
            m_p2[u]  = '1;
            m_k[u]   = 0;
            e_lvl[u] = '0;
            for (int i = 0; i < N; i++) begin
                m_run[u][i]  = 0;
                m_act[u][i]  = 0;
                m_held[u][i] = 0;
            end
            return;
        end
        smp     = ~m_p2[u];
        m_p2[u] = m_p1[u];
        m_p1[u] = pin;
        tk      = (m_k[u] % d) == (d - 1);
        m_k[u]++;
        for (int i = 0; i < N; i++) begin
            if (tk) begin
                if (smp[i] == e_lvl[u][i]) begin
                    m_run[u][i] = 0;
                end else begin
                    m_run[u][i]++;
                    if (m_run[u][i] == ST) begin
                        m_run[u][i] = 0;
                        e_lvl[u][i] = ~e_lvl[u][i];
                        if (e_lvl[u][i]) e_prs[u][i] = 1'b1;
                        else             e_rel[u][i] = 1'b1;
                    end
                end
            end
            if (e_prs[u][i]) begin
                m_act[u][i]  = 1;
                m_held[u][i] = 0;
            end else if (e_rel[u][i]) begin
                m_act[u][i] = 0;
            end else if (tk && m_act[u][i]) begin
                if (!en[i]) begin
                    m_held[u][i] = 0;
                end else begin
                    m_held[u][i]++;
                    if (m_held[u][i] == RD ||
                        (m_held[u][i] > RD &&
                         (m_held[u][i] - RD) % RR == 0))
                        e_rpt[u][i] = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0, 1, rst_n, btn_in, rep_en);
        model_step(1, 4, rst_n, btn_in, rep_en);
        #1;
        chk("lvl1", 32'(lvl1), 32'(e_lvl[0]));
        chk("prs1", 32'(prs1), 32'(e_prs[0]));
        chk("rel1", 32'(rel1), 32'(e_rel[0]));
        chk("rpt1", 32'(rpt1), 32'(e_rpt[0]));
        chk("lvl4", 32'(lvl4), 32'(e_lvl[1]));
        chk("prs4", 32'(prs4), 32'(e_prs[1]));
        chk("rel4", 32'(rel4), 32'(e_rel[1]));
        chk("rpt4", 32'(rpt4), 32'(e_rpt[1]));
        chk("rpt_prs1", 32'(rpt1 & prs1), 32'd0);
        chk("rpt_prs4", 32'(rpt4 & prs4), 32'd0);
    endtask

    logic [N-1:0] pressed;
    int           rem[N];
    int           rst_hold;

    initial begin
        checks   = 0;
        failures = 0;

        // All buttons held through reset, then released from reset.
        rst_n  = 1'b0;
        btn_in = '0;
        rep_en = '0;
        for (int c = 0; c < 3; c++) step();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (c == 4)  chk("pre_lvl", 32'(lvl1), 32'h00);
            if (c == 5)  chk("rst_lvl", 32'(lvl1), 32'h1f);
            if (c == 5)  chk("rst_prs", 32'(prs1), 32'h1f);
            if (c == 6)  chk("rst_prs_end", 32'(prs1), 32'h00);
            if (c == 14) chk("div4_pre", 32'(lvl4), 32'h00);
            if (c == 15) chk("div4_lvl", 32'(lvl4), 32'h1f);
            if (c == 15) chk("div4_prs", 32'(prs4), 32'h1f);
        end

        // Random traffic: short glitches, long holds, rep_en toggles and
        // occasional resets landing mid-press or mid-repeat.
        pressed  = '1;
        rep_en   = N'($urandom);
        rst_hold = 0;
        for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 10);
        for (int c = 0; c < 6000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    pressed[i] = ~pressed[i];
                    rem[i] = ($urandom_range(0, 2) == 0) ?
                             $urandom_range(1, 5) : $urandom_range(6, 60);
                end else begin
                    rem[i]--;
                end
                if ($urandom_range(0, 39) == 0) rep_en[i] = ~rep_en[i];
            end
            btn_in = ~pressed;
            if (rst_hold > 0) begin
                rst_n = 1'b0;
                rst_hold--;
            end else begin
                rst_n = 1'b1;
                if ($urandom_range(0, 499) == 0)
                    rst_hold = $urandom_range(1, 3);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
